// File: rtl/legv8_ctrl_pkg.sv
// LEGv8 multicycle controller shared types: FSM states, instruction classes,
// 11-bit opcode patterns, ALUop and pc_src encodings.
// Pure declarations; no logic lives here.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_R       = 3'd1,
    CLS_ADDI    = 3'd2,
    CLS_LDUR    = 3'd3,
    CLS_STUR    = 3'd4,
    CLS_CBZ     = 3'd5,
    CLS_CBNZ    = 3'd6,
    CLS_B       = 3'd7
  } class_e;

  // Exact-match opcodes
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // Wildcard opcodes: pattern plus care-mask (1 = bit must match)
  localparam logic [10:0] OPC_ADDI  = 11'b10010001000;
  localparam logic [10:0] MSK_ADDI  = 11'b11111111110;
  localparam logic [10:0] OPC_CBZ   = 11'b10110100000;
  localparam logic [10:0] OPC_CBNZ  = 11'b10110101000;
  localparam logic [10:0] MSK_CB    = 11'b11111111000;
  localparam logic [10:0] OPC_B     = 11'b00010100000;
  localparam logic [10:0] MSK_B     = 11'b11111100000;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_CB    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_COND   = 2'b01;
  localparam logic [1:0] PCSRC_UNCOND = 2'b10;

  function automatic logic opc_match(input logic [10:0] opc,
                                     input logic [10:0] pat,
                                     input logic [10:0] msk);
    return ((opc ^ pat) & msk) == 11'd0;
  endfunction

endpackage

// File: rtl/legv8_opcode_decoder.sv
// Combinational opcode -> instruction class lookup.
// Zero latency; pure combinational, no handshake.
// Anything not recognised maps to CLS_ILLEGAL.
module legv8_opcode_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opc,
  output class_e      cls
);

  // Priority order is irrelevant: the patterns are mutually exclusive.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (opc == OPC_ADD || opc == OPC_SUB || opc == OPC_AND || opc == OPC_ORR)
      cls = CLS_R;
    else if (opc_match(opc, OPC_ADDI, MSK_ADDI))
      cls = CLS_ADDI;
    else if (opc == OPC_LDUR)
      cls = CLS_LDUR;
    else if (opc == OPC_STUR)
      cls = CLS_STUR;
    else if (opc_match(opc, OPC_CBZ, MSK_CB))
      cls = CLS_CBZ;
    else if (opc_match(opc, OPC_CBNZ, MSK_CB))
      cls = CLS_CBNZ;
    else if (opc_match(opc, OPC_B, MSK_B))
      cls = CLS_B;
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB with memory wait timeout.
// Outputs are combinational from state, latched class, zero and mem_ready.
// FETCH and MEM stall on mem_ready; MEM_TIMEOUT wait cycles raise bus_err and return to IDLE.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int OPC_W       = 11,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg2Loc,
  output logic               ALUsrc,
  output logic               mem2Reg,
  output logic               regWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               busy,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               illegal,
  output logic               bus_err,
  output logic [2:0]         state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d, end_state;
  class_e           class_q, class_d, dec_class;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             mem_wait, timeout;
  logic [1:0]       aluop_sel;
  logic             opc_unused;

  // Only the top 11 opcode bits carry the instruction class.
  assign opc_unused = ^opcode;

  legv8_opcode_decoder u_dec (
    .opc (opcode[OPC_W-1 -: 11]),
    .cls (dec_class)
  );

  assign mem_wait = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
  assign timeout  = mem_wait && (wait_q == CNT_W'(MEM_TIMEOUT - 1));

  // State, latched class and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      class_q <= CLS_ILLEGAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
    end
  end

  // Next state, class capture on the completing fetch, and wait counting.
  always_comb begin
    end_state = run ? ST_FETCH : ST_IDLE;
    state_d   = state_q;
    class_d   = (state_q == ST_FETCH && mem_ready) ? dec_class : class_q;
    // Any exit from FETCH/MEM (ready or timeout) clears the counter.
    wait_d    = (mem_wait && !timeout) ? wait_q + CNT_W'(1) : '0;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (timeout)        state_d = ST_IDLE;
        else if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = (class_q == CLS_ILLEGAL) ? end_state : ST_EXEC;
      ST_EXEC: begin
        case (class_q)
          CLS_R, CLS_ADDI:    state_d = ST_WB;
          CLS_LDUR, CLS_STUR: state_d = ST_MEM;
          default:            state_d = end_state;
        endcase
      end
      ST_MEM: begin
        if (timeout)        state_d = ST_IDLE;
        else if (mem_ready) state_d = (class_q == CLS_LDUR) ? ST_WB : end_state;
      end
      ST_WB:     state_d = end_state;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control strobes; IDLE (and therefore reset) leaves every output at 0.
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PCSRC_SEQ;
    reg2Loc   = 1'b0;
    ALUsrc    = 1'b0;
    mem2Reg   = 1'b0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    illegal   = 1'b0;
    bus_err   = timeout;
    aluop_sel = ALUOP_MEM;
    busy      = (state_q != ST_IDLE);
    state     = state_q;
    case (state_q)
      ST_FETCH: begin
        memRead = !timeout;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PCSRC_SEQ;
        end
      end
      ST_DECODE: begin
        reg2Loc = (class_q == CLS_STUR || class_q == CLS_CBZ || class_q == CLS_CBNZ);
        illegal = (class_q == CLS_ILLEGAL);
      end
      ST_EXEC: begin
        ALUsrc = (class_q == CLS_ADDI || class_q == CLS_LDUR || class_q == CLS_STUR);
        case (class_q)
          CLS_R, CLS_ADDI: aluop_sel = ALUOP_RTYPE;
          CLS_CBZ: begin
            aluop_sel = ALUOP_CB;
            pc_write  = zero;
            pc_src    = PCSRC_COND;
          end
          CLS_CBNZ: begin
            aluop_sel = ALUOP_CB;
            pc_write  = !zero;
            pc_src    = PCSRC_COND;
          end
          CLS_B: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_UNCOND;
          end
          default: aluop_sel = ALUOP_MEM;
        endcase
      end
      ST_MEM: begin
        memRead  = !timeout && (class_q == CLS_LDUR);
        memWrite = !timeout && (class_q == CLS_STUR);
      end
      ST_WB: begin
        regWrite = 1'b1;
        mem2Reg  = (class_q == CLS_LDUR);
      end
      default: ;
    endcase
    ALUop = ALUOP_W'(aluop_sel);
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Randomised instruction stream against a per-class cycle-by-cycle reference trace.
module tb_legv8_multicycle_ctrl;
  import legv8_ctrl_pkg::*;

  localparam int TMO = 15;
  localparam int N_INSTR = 80;

  typedef enum int {K_R, K_ADDI, K_LDUR, K_STUR, K_CBZ, K_CBNZ, K_B, K_ILL} kind_e;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] psrc;
    logic       r2l;
    logic       asrc;
    logic       m2r;
    logic       rw;
    logic       mrd;
    logic       mwr;
    logic       busy;
    logic [2:0] aop;
    logic       ill;
    logic       berr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [12:0] opcode;
  logic        mem_ready;
  logic        zero;
  logic        ir_write, pc_write, reg2Loc, ALUsrc, mem2Reg, regWrite;
  logic        memRead, memWrite, busy, illegal, bus_err;
  logic [1:0]  pc_src;
  logic [2:0]  ALUop;
  logic [2:0]  state;
  obs_t        obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl #(.OPC_W(13), .ALUOP_W(3), .MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg2Loc   (reg2Loc),
    .ALUsrc    (ALUsrc),
    .mem2Reg   (mem2Reg),
    .regWrite  (regWrite),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .busy      (busy),
    .ALUop     (ALUop),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .state     (state)
  );

  assign obs = {state, ir_write, pc_write, pc_src, reg2Loc, ALUsrc, mem2Reg, regWrite,
                memRead, memWrite, busy, ALUop, illegal, bus_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] ro();
    return 11'($urandom);
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    e.busy = (st != ST_IDLE);
    return e;
  endfunction

  // Reference classification straight from the opcode table.
  function automatic kind_e classify(input logic [10:0] o);
    if (o == 11'b10001011000 || o == 11'b11001011000 ||
        o == 11'b10001010000 || o == 11'b10101010000) return K_R;
    if (o[10:1] == 10'b1001000100) return K_ADDI;
    if (o == 11'b11111000010) return K_LDUR;
    if (o == 11'b11111000000) return K_STUR;
    if (o[10:3] == 8'b10110100) return K_CBZ;
    if (o[10:3] == 8'b10110101) return K_CBNZ;
    if (o[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [10:0] gen_opc(input kind_e k);
    logic [10:0] o;
    case (k)
      K_R: begin
        case ($urandom_range(0, 3))
          0: o = 11'b10001011000;
          1: o = 11'b11001011000;
          2: o = 11'b10001010000;
          default: o = 11'b10101010000;
        endcase
      end
      K_ADDI: o = {10'b1001000100, rb()};
      K_LDUR: o = 11'b11111000010;
      K_STUR: o = 11'b11111000000;
      K_CBZ:  o = {8'b10110100, 3'($urandom)};
      K_CBNZ: o = {8'b10110101, 3'($urandom)};
      K_B:    o = {6'b000101, 5'($urandom)};
      default: begin
        o = ro();
        while (classify(o) != K_ILL) o = ro();
      end
    endcase
    return o;
  endfunction

  // One clock: drive inputs on the falling edge, compare shortly after.
  task automatic cyc(input logic mr, input logic z, input logic rn,
                     input logic [10:0] opc, input obs_t e, input string tg);
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    run       = rn;
    opcode    = {opc, 2'($urandom)};
    #1;
    check(tg, 32'(obs), 32'(e));
  endtask

  // w cycles of mem_ready=0; the TMO-th such cycle is the bus error.
  task automatic wait_phase(input logic [2:0] st, input int w, input logic rd, input logic wr,
                            input string tg, output bit to);
    obs_t e;
    to = 0;
    for (int k = 0; k < w && !to; k++) begin
      e = mk(st);
      if (k == TMO - 1) begin
        e.berr = 1'b1;
        to = 1;
      end else begin
        e.mrd = rd;
        e.mwr = wr;
      end
      cyc(1'b0, rb(), rb(), ro(), e, $sformatf("%s_wait%0d", tg, k));
    end
  endtask

  // Starts with the DUT in FETCH; ends with it in FETCH (idle=0) or IDLE (idle=1).
  task automatic run_instr(input int idx, input kind_e k, input logic [10:0] opc,
                           input int wf, input int wm, input logic ra, output bit idle);
    obs_t  e;
    bit    to;
    logic  z;
    string tg;
    tg = $sformatf("i%0d", idx);
    idle = 0;
    wait_phase(ST_FETCH, wf, 1'b1, 1'b0, {tg, "_fetch"}, to);
    if (to) begin idle = 1; return; end
    e = mk(ST_FETCH); e.mrd = 1; e.irw = 1; e.pcw = 1;
    cyc(1'b1, rb(), rb(), opc, e, {tg, "_fetch_rdy"});

    e = mk(ST_DECODE);
    e.r2l = (k == K_STUR || k == K_CBZ || k == K_CBNZ);
    e.ill = (k == K_ILL);
    if (k == K_ILL) begin
      cyc(rb(), rb(), ra, ro(), e, {tg, "_decode"});
      idle = ~ra;
      return;
    end
    cyc(rb(), rb(), rb(), ro(), e, {tg, "_decode"});

    e = mk(ST_EXEC);
    z = rb();
    case (k)
      K_R, K_ADDI:  e.aop = 3'd2;
      K_CBZ, K_CBNZ: e.aop = 3'd1;
      default:      e.aop = 3'd0;
    endcase
    e.asrc = (k == K_ADDI || k == K_LDUR || k == K_STUR);
    if (k == K_CBZ)  begin e.pcw = z;  e.psrc = 2'd1; end
    if (k == K_CBNZ) begin e.pcw = ~z; e.psrc = 2'd1; end
    if (k == K_B)    begin e.pcw = 1;  e.psrc = 2'd2; end
    if (k == K_CBZ || k == K_CBNZ || k == K_B) begin
      cyc(rb(), z, ra, ro(), e, {tg, "_exec"});
      idle = ~ra;
      return;
    end
    cyc(rb(), z, rb(), ro(), e, {tg, "_exec"});

    if (k == K_LDUR || k == K_STUR) begin
      wait_phase(ST_MEM, wm, k == K_LDUR, k == K_STUR, {tg, "_mem"}, to);
      if (to) begin idle = 1; return; end
      e = mk(ST_MEM); e.mrd = (k == K_LDUR); e.mwr = (k == K_STUR);
      if (k == K_STUR) begin
        cyc(1'b1, rb(), ra, ro(), e, {tg, "_mem_rdy"});
        idle = ~ra;
        return;
      end
      cyc(1'b1, rb(), rb(), ro(), e, {tg, "_mem_rdy"});
    end

    e = mk(ST_WB); e.rw = 1; e.m2r = (k == K_LDUR);
    cyc(rb(), rb(), ra, ro(), e, {tg, "_wb"});
    idle = ~ra;
  endtask

  initial begin
    obs_t        e;
    bit          at_idle;
    kind_e       k;
    logic [10:0] o;
    int          wf, wm;
    logic        ra;

    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    #2;
    check("reset_outputs", 32'(obs), 32'(mk(ST_IDLE)));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(rb(), rb(), 1'b0, ro(), mk(ST_IDLE), "idle_hold");

    at_idle = 1;
    for (int i = 0; i < N_INSTR; i++) begin
      if (at_idle) cyc(rb(), rb(), 1'b1, ro(), mk(ST_IDLE), $sformatf("i%0d_go", i));
      k  = kind_e'($urandom_range(0, 7));
      if (i == 1) k = K_R;
      if (i == 3) k = K_LDUR;
      if (i == 4) k = K_CBZ;
      if (i == 6) k = K_B;
      o  = gen_opc(k);
      if (i == 0) begin k = K_ILL; o = 11'b11111111111; end
      if (i == 1) o = 11'b10001011000;
      wf = ($urandom_range(0, 19) == 0) ? TMO + 2 : $urandom_range(0, 2);
      wm = ($urandom_range(0, 19) == 0) ? TMO + 2 : $urandom_range(0, 4);
      if (i < 3) begin wf = 0; wm = 0; end
      if (i == 3) wm = TMO + 3;
      if (i == 5) wf = TMO;
      ra = ($urandom_range(0, 3) != 0);
      if (i < 2) ra = 1'b1;
      run_instr(i, k, o, wf, wm, ra, at_idle);
      if (at_idle && rb())
        cyc(rb(), rb(), 1'b0, ro(), mk(ST_IDLE), $sformatf("i%0d_linger", i));
    end

    // STUR interrupted by reset while waiting in MEM.
    if (at_idle) cyc(rb(), rb(), 1'b1, ro(), mk(ST_IDLE), "rst_go");
    e = mk(ST_FETCH); e.mrd = 1; e.irw = 1; e.pcw = 1;
    cyc(1'b1, rb(), rb(), 11'b11111000000, e, "rst_fetch");
    e = mk(ST_DECODE); e.r2l = 1;
    cyc(rb(), rb(), rb(), ro(), e, "rst_decode");
    e = mk(ST_EXEC); e.asrc = 1;
    cyc(rb(), rb(), rb(), ro(), e, "rst_exec");
    e = mk(ST_MEM); e.mwr = 1;
    cyc(1'b0, rb(), 1'b1, ro(), e, "rst_mem_wait0");
    cyc(1'b0, rb(), 1'b1, ro(), e, "rst_mem_wait1");
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs), 32'(mk(ST_IDLE)));
    @(posedge clk);
    #1;
    check("rst_held", 32'(obs), 32'(mk(ST_IDLE)));
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 3; i++) cyc(rb(), rb(), 1'b0, ro(), mk(ST_IDLE), "post_rst_idle");
    cyc(rb(), rb(), 1'b1, ro(), mk(ST_IDLE), "post_rst_go");
    e = mk(ST_FETCH); e.mrd = 1;
    cyc(1'b0, rb(), 1'b0, ro(), e, "post_rst_fetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
